// File: rtl/insn_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : insn_fetch_if
//  Description : Execute-stage control, instruction-memory and decoder
//                handshake signals of the instruction fetch front end.
//  Revision    : 1.0  initial release
// ============================================================================
interface insn_fetch_if;
    logic        i_redirect;
    logic [63:0] i_redirect_pc;
    logic        i_halt;
    logic        o_mem_req;
    logic [63:0] o_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_data;
    logic        o_insn_valid;
    logic [31:0] o_insn;
    logic [63:0] o_insn_pc;
    logic        i_insn_ready;
    logic        o_halted;
    logic        o_fault;

    // Fetch unit side
    modport master (
        input  i_redirect, i_redirect_pc, i_halt, i_mem_ack, i_mem_data, i_insn_ready,
        output o_mem_req, o_mem_addr, o_insn_valid, o_insn, o_insn_pc, o_halted, o_fault
    );

    // Environment side: execute stage, instruction memory and decoder
    modport slave (
        output i_redirect, i_redirect_pc, i_halt, i_mem_ack, i_mem_data, i_insn_ready,
        input  o_mem_req, o_mem_addr, o_insn_valid, o_insn, o_insn_pc, o_halted, o_fault
    );
endinterface
`default_nettype wire

// File: rtl/insn_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : insn_fetch
//  Description : Instruction fetch front end: owns the fetch PC, issues one
//                outstanding word read at a time and buffers returned words
//                in a small FIFO for the decoder. Optional macro
//                INSN_FETCH_ALIGN_CHECK_EN halts with a fault on misaligned
//                redirect targets instead of silently aligning them.
//  Revision    : 1.0  initial release
// ============================================================================
module insn_fetch #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          FIFO_DEPTH = 2
) (
    input  wire logic      i_clk,
    input  wire logic      i_rst,
    insn_fetch_if.master   bus
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [63:0]        r_pc, w_pc_nxt;
    logic [63:0]        r_addr, w_addr_nxt;
    logic               r_pend, w_pend_nxt;
    logic               r_fault, w_fault_nxt;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [31:0]        r_fifo_data [FIFO_DEPTH];
    logic [63:0]        r_fifo_pc   [FIFO_DEPTH];

    logic               w_req, w_valid, w_push, w_pop, w_flush;
    logic               w_halt_take, w_redir_take, w_redir_bad, w_outstanding;
    logic [63:0]        w_redir_tgt;

`ifdef INSN_FETCH_ALIGN_CHECK_EN
    assign w_redir_bad = (bus.i_redirect_pc[1:0] != 2'b00);
    assign w_redir_tgt = bus.i_redirect_pc;
`else
    assign w_redir_bad = 1'b0;
    assign w_redir_tgt = bus.i_redirect_pc & ~64'h3;
`endif

    // Credit check uses registered count only, keeping i_insn_ready off the request path
    assign w_req = !i_rst && (((r_state == ST_FETCH) && (r_count < c_DEPTH)) ||
                              (r_state == ST_WAIT) || (r_state == ST_DRAIN) ||
                              ((r_state == ST_HALTED) && r_pend));
    assign w_valid       = !i_rst && (r_count != '0);
    assign w_halt_take   = bus.i_halt && (r_state != ST_HALTED);
    assign w_redir_take  = bus.i_redirect && !bus.i_halt && (r_state != ST_HALTED);
    assign w_flush       = w_halt_take || w_redir_take;
    assign w_outstanding = w_req && !bus.i_mem_ack;
    assign w_push        = w_req && bus.i_mem_ack && !w_flush &&
                           ((r_state == ST_FETCH) || (r_state == ST_WAIT));
    assign w_pop         = w_valid && bus.i_insn_ready && !w_flush;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend;
        w_fault_nxt = r_fault;
        if (w_halt_take) begin
            w_state_nxt = ST_HALTED;
            w_pend_nxt  = w_outstanding;
        end else if (w_redir_take) begin
            w_pc_nxt = w_redir_tgt;
            if (w_redir_bad) begin
                w_state_nxt = ST_HALTED;
                w_pend_nxt  = w_outstanding;
                w_fault_nxt = 1'b1;
            end else begin
                w_state_nxt = w_outstanding ? ST_DRAIN : ST_FETCH;
            end
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_push)
                        w_pc_nxt = r_pc + 64'd4;
                    else if (w_req)
                        w_state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_push) begin
                        w_pc_nxt    = r_pc + 64'd4;
                        w_state_nxt = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (bus.i_mem_ack)
                        w_state_nxt = ST_FETCH;
                end
                ST_HALTED: begin
                    if (bus.i_mem_ack)
                        w_pend_nxt = 1'b0;
                end
                default: w_state_nxt = ST_FETCH;
            endcase
        end
    end

    // The presented address freezes while a request is in flight, even if pc is redirected
    assign w_addr_nxt = w_outstanding ? r_addr : w_pc_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_FETCH;
            r_pc     <= RESET_PC;
            r_addr   <= RESET_PC;
            r_pend   <= 1'b0;
            r_fault  <= 1'b0;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_addr  <= w_addr_nxt;
            r_pend  <= w_pend_nxt;
            r_fault <= w_fault_nxt;
            if (w_flush) begin
                r_count  <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                if (w_push && !w_pop)
                    r_count <= r_count + c_CNT_W'(1);
                else if (w_pop && !w_push)
                    r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= bus.i_mem_data;
            r_fifo_pc[r_wr_ptr]   <= r_pc;
        end
    end

    assign bus.o_mem_req    = w_req;
    assign bus.o_mem_addr   = r_addr;
    assign bus.o_insn_valid = w_valid;
    assign bus.o_insn       = r_fifo_data[r_rd_ptr];
    assign bus.o_insn_pc    = r_fifo_pc[r_rd_ptr];
    assign bus.o_halted     = (r_state == ST_HALTED);
    assign bus.o_fault      = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_insn_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_insn_fetch
//  Description : Self-checking bench for insn_fetch: directed scenarios with a
//                latency-configurable memory model and a decoder-side scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_insn_fetch;

    typedef struct packed {
        logic [31:0] insn;
        logic [63:0] pc;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned lat;
    logic [63:0] stale_addr;
    int          n_cmp = 0;
    int          n_err = 0;
    word_t       exp_q[$];

    insn_fetch_if bus();

    insn_fetch #(.RESET_PC(64'h0), .FIFO_DEPTH(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return (a == stale_addr) ? 32'h0BAD_0BAD : {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    task automatic expect_word(input logic [63:0] pc);
        word_t w;
        w.insn = {16'hC0DE, pc[15:0]};
        w.pc   = pc;
        exp_q.push_back(w);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_addr(input logic [63:0] a, input int budget);
        int k;
        k = 0;
        while (!(bus.o_mem_req === 1'b1 && bus.o_mem_addr === a) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_addr timeout: got addr %h req %b, want addr %h req 1",
                     bus.o_mem_addr, bus.o_mem_req, a);
        end
    endtask

    task automatic wait_req_low(input int budget);
        int k;
        k = 0;
        while (bus.o_mem_req !== 1'b0 && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_req_low timeout: got req %b, want 0", bus.o_mem_req);
        end
    endtask

    // Instruction memory: acks after lat waiting cycles (0 = same cycle as request)
    initial begin
        int unsigned cnt;
        cnt = 0;
        bus.i_mem_ack  = 1'b0;
        bus.i_mem_data = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.o_mem_req === 1'b1) begin
                if (cnt >= lat) begin
                    bus.i_mem_ack  = 1'b1;
                    bus.i_mem_data = word_at(bus.o_mem_addr);
                    cnt = 0;
                end else begin
                    bus.i_mem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                bus.i_mem_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    // Decoder-side monitor: every accepted word is checked against the scoreboard
    initial begin
        word_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && bus.o_insn_valid === 1'b1 && bus.i_insn_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got insn %h pc %h, want no word",
                             bus.o_insn, bus.o_insn_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("insn_data", {32'h0, bus.o_insn}, {32'h0, e.insn});
                    check("insn_pc", bus.o_insn_pc, e.pc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100us, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;
        rst = 1'b1;
        lat = 0;
        stale_addr = 64'h3;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = 64'h0;
        bus.i_halt        = 1'b0;
        bus.i_insn_ready  = 1'b0;
        tick();
        tick();
        check("rst_req",    {63'h0, bus.o_mem_req},    64'h0);
        check("rst_valid",  {63'h0, bus.o_insn_valid}, 64'h0);
        check("rst_halted", {63'h0, bus.o_halted},     64'h0);
        check("rst_fault",  {63'h0, bus.o_fault},      64'h0);
        check("rst_addr",   bus.o_mem_addr,            64'h0);

        // Zero-latency memory, decoder always ready: one word per cycle
        for (int i = 0; i < 7; i++) expect_word(64'(4 * i));
        rst = 1'b0;
        bus.i_insn_ready = 1'b1;
        #1;
        check("req_after_release", {63'h0, bus.o_mem_req}, 64'h1);
        for (int j = 1; j <= 8; j++) begin
            tick();
            check("stream_addr", bus.o_mem_addr, 64'(4 * j));
        end
        rst = 1'b1;
        bus.i_insn_ready = 1'b0;
        tick();
        tick();

        // Latency 3, decoder stalled: fetch stops at FIFO_DEPTH words
        lat = 3;
        stale_addr = 64'hC;
        expect_word(64'h0);
        expect_word(64'h4);
        expect_word(64'h8);
        rst = 1'b0;
        tick();
        tick();
        check("wait_req",   {63'h0, bus.o_mem_req},    64'h1);
        check("wait_addr",  bus.o_mem_addr,            64'h0);
        check("wait_valid", {63'h0, bus.o_insn_valid}, 64'h0);
        repeat (10) tick();
        check("full_req",   {63'h0, bus.o_mem_req},    64'h0);
        check("full_addr",  bus.o_mem_addr,            64'h8);
        check("full_valid", {63'h0, bus.o_insn_valid}, 64'h1);
        check("full_head",  bus.o_insn_pc,             64'h0);
        bus.i_insn_ready = 1'b1;
        tick();
        check("req_resumes", {63'h0, bus.o_mem_req}, 64'h1);

        // Redirect while the read of 0xC is in flight; its stale word must vanish
        wait_addr(64'hC, 20);
        tick();
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 64'h100;
        bus.i_insn_ready  = 1'b0;
        tick();
        bus.i_redirect = 1'b0;
        check("drain_req",   {63'h0, bus.o_mem_req},    64'h1);
        check("drain_addr",  bus.o_mem_addr,            64'hC);
        check("drain_valid", {63'h0, bus.o_insn_valid}, 64'h0);
        wait_req_low(40);
        check("redir_valid", {63'h0, bus.o_insn_valid}, 64'h1);
        check("redir_pc",    bus.o_insn_pc,             64'h100);
        check("redir_insn",  {32'h0, bus.o_insn},       64'hC0DE0100);

        // Halt with a full FIFO and no request outstanding
        bus.i_halt = 1'b1;
        tick();
        bus.i_halt = 1'b0;
        check("halt_valid",  {63'h0, bus.o_insn_valid}, 64'h0);
        check("halt_halted", {63'h0, bus.o_halted},     64'h1);
        check("halt_req",    {63'h0, bus.o_mem_req},    64'h0);
        bus.i_insn_ready = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (bus.o_mem_req !== 1'b0 || bus.o_insn_valid !== 1'b0) seen = 1'b1;
        end
        check("halted_quiet", {63'h0, seen}, 64'h0);

        // Halt while a request is outstanding: request held until ack, then dropped
        rst = 1'b1;
        bus.i_insn_ready = 1'b0;
        tick();
        tick();
        lat = 3;
        rst = 1'b0;
        tick();
        bus.i_halt = 1'b1;
        tick();
        bus.i_halt = 1'b0;
        check("hpend_halted", {63'h0, bus.o_halted},  64'h1);
        check("hpend_req",    {63'h0, bus.o_mem_req}, 64'h1);
        check("hpend_addr",   bus.o_mem_addr,         64'h0);
        repeat (4) tick();
        check("hpend_req_done", {63'h0, bus.o_mem_req},    64'h0);
        check("hpend_valid",    {63'h0, bus.o_insn_valid}, 64'h0);

        // Redirect and halt together: halt wins, pc untouched
        rst = 1'b1;
        tick();
        tick();
        lat = 0;
        rst = 1'b0;
        tick();
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 64'h200;
        bus.i_halt        = 1'b1;
        tick();
        bus.i_redirect = 1'b0;
        bus.i_halt     = 1'b0;
        check("rh_halted", {63'h0, bus.o_halted},      64'h1);
        check("rh_addr",   bus.o_mem_addr,             64'h4);
        check("rh_req",    {63'h0, bus.o_mem_req},     64'h0);
        check("rh_valid",  {63'h0, bus.o_insn_valid},  64'h0);
        check("rh_fault",  {63'h0, bus.o_fault},       64'h0);

        // Misaligned redirect target 0x102
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 64'h102;
        tick();
        bus.i_redirect = 1'b0;
`ifdef INSN_FETCH_ALIGN_CHECK_EN
        check("mis_fault",  {63'h0, bus.o_fault},   64'h1);
        check("mis_halted", {63'h0, bus.o_halted},  64'h1);
        check("mis_req",    {63'h0, bus.o_mem_req}, 64'h0);
        check("mis_addr",   bus.o_mem_addr,         64'h102);
`else
        expect_word(64'h100);
        expect_word(64'h104);
        check("mis_fault",  {63'h0, bus.o_fault},   64'h0);
        check("mis_halted", {63'h0, bus.o_halted},  64'h0);
        check("mis_addr",   bus.o_mem_addr,         64'h100);
        check("mis_req",    {63'h0, bus.o_mem_req}, 64'h1);
        bus.i_insn_ready = 1'b1;
        repeat (3) tick();
        bus.i_insn_ready = 1'b0;
`endif
        rst = 1'b1;
        tick();
        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
